// File: rtl/uart_pkt_tx_if.sv
// uart_pkt_tx_if -- packet handshake and serial output bundle for uart_pkt_tx.
// master: the packet source (application / loopback logic).
// slave : the transmitter itself.
interface uart_pkt_tx_if;
  logic         pkt_en;    // start request, sampled every cycle
  logic [127:0] pkt_data;  // payload, sampled on acceptance only
  logic         tx_busy;   // packet in flight
  logic         tx_done;   // one-cycle pulse on the last stop-bit cycle
  logic         uart_txd;  // serial line, idle high

  modport master (
    output pkt_en,
    output pkt_data,
    input  tx_busy,
    input  tx_done,
    input  uart_txd
  );

  modport slave (
    input  pkt_en,
    input  pkt_data,
    output tx_busy,
    output tx_done,
    output uart_txd
  );
endinterface

// File: rtl/uart_pkt_tx.sv
// uart_pkt_tx -- sends a 128-bit word as 16 back-to-back UART bytes,
// byte 0 (pkt_data[7:0]) first, each byte LSB first.
// Default framing is 8N1. Defining UART_TX_PARITY_EN adds an even-parity
// bit after the data bits (8E1). GAP_BITS idle bit-times separate the bytes
// of one packet; no gap follows the final byte.
module uart_pkt_tx #(
  parameter int CLK_FREQ = 50000000,
  parameter int UART_BPS = 115200,
  parameter int GAP_BITS = 0
) (
  input  logic           sys_clk,
  input  logic           sys_rst_n,
  uart_pkt_tx_if.slave   bus
);

  localparam int BPS_CNT = CLK_FREQ / UART_BPS;
  localparam int BAUD_W  = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BPS_CNT - 1);
  // With GAP_BITS = 0 this wraps to 15 and the GAP state is never entered.
  localparam logic [3:0]        GAP_LAST  = 4'(GAP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_GAP
  } state_t;

  state_t              state_q, state_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [3:0]          bit_q, bit_d;    // data bit index, reused as gap bit count
  logic [3:0]          byte_q, byte_d;
  logic [127:0]        shift_q, shift_d;
  logic                txd_q, txd_d;
  logic                baud_end;
`ifdef UART_TX_PARITY_EN
  logic                parity_q, parity_d;
`endif

  assign baud_end = (baud_q == BAUD_LAST);

  // Next-state, counter and shift-register logic.
  always_comb begin
    // NOTE: every signal gets a default here, so no path through the case
    // below leaves one unassigned and no latch is inferred.
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    shift_d = shift_q;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif

    // Baud counter runs in every non-idle state; all transitions out of
    // those states happen at baud_end, so it restarts at 0 on each change.
    if (state_q != S_IDLE) begin
      baud_d = baud_end ? '0 : baud_q + BAUD_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (bus.pkt_en) begin
          state_d = S_START;
          shift_d = bus.pkt_data;
          baud_d  = '0;
          bit_d   = '0;
          byte_d  = '0;
        end
      end

      S_START: begin
        if (baud_end) begin
          state_d = S_DATA;
          bit_d   = '0;
`ifdef UART_TX_PARITY_EN
          parity_d = ^shift_q[7:0];
`endif
        end
      end

      S_DATA: begin
        if (baud_end) begin
          // After eight shifts the next byte sits in shift_q[7:0].
          shift_d = shift_q >> 1;
          if (bit_q == 4'd7) begin
            bit_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud_end) begin
          state_d = S_STOP;
        end
      end
`endif

      S_STOP: begin
        if (baud_end) begin
          byte_d = byte_q + 4'd1;
          if (byte_q == 4'd15) begin
            state_d = S_IDLE;
          end else if (GAP_BITS > 0) begin
            state_d = S_GAP;
            bit_d   = '0;
          end else begin
            state_d = S_START;
          end
        end
      end

      S_GAP: begin
        if (baud_end) begin
          if (bit_q == GAP_LAST) begin
            state_d = S_START;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Line level for the coming cycle, decoded from the next state so that the
  // registered txd changes on the same edge as the state.
  always_comb begin
    txd_d = 1'b1;
    case (state_d)
      S_START:  txd_d = 1'b0;
      S_DATA:   txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: txd_d = parity_d;
`endif
      default:  txd_d = 1'b1;
    endcase
  end

  // Control state and the output flop; reset aborts a packet immediately.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      txd_q   <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      txd_q   <= txd_d;
    end
  end

  // Payload datapath.
  // NOTE: no reset here; the shift register is always loaded on acceptance
  // before any of its bits reach the line.
  always_ff @(posedge sys_clk) begin
    shift_q <= shift_d;
`ifdef UART_TX_PARITY_EN
    parity_q <= parity_d;
`endif
  end

  assign bus.uart_txd = txd_q;
  assign bus.tx_busy  = (state_q != S_IDLE);
  assign bus.tx_done  = (state_q == S_STOP) && (byte_q == 4'd15) && baud_end;

endmodule

// File: tb/tb_uart_pkt_tx.sv
// tb_uart_pkt_tx -- randomized self-checking bench for uart_pkt_tx.
// Two instances share clock and reset: one with GAP_BITS=0, one with
// GAP_BITS=2. Expected line levels come from a per-packet list of frame bits.
module tb_uart_pkt_tx;

  localparam int CLK_FREQ = 1000000;
  localparam int UART_BPS = 100000;
  localparam int BPS      = CLK_FREQ / UART_BPS;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FRAME = 10 + PAR;

  logic clk = 1'b0;
  logic rst_n;

  int tests = 0;
  int fails = 0;

  uart_pkt_tx_if bus0 ();
  uart_pkt_tx_if bus2 ();

  uart_pkt_tx #(
    .CLK_FREQ (CLK_FREQ),
    .UART_BPS (UART_BPS),
    .GAP_BITS (0)
  ) u_dut0 (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .bus       (bus0.slave)
  );

  uart_pkt_tx #(
    .CLK_FREQ (CLK_FREQ),
    .UART_BPS (UART_BPS),
    .GAP_BITS (2)
  ) u_dut2 (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .bus       (bus2.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic en, input logic [127:0] d);
    if (sel == 0) begin
      bus0.pkt_en   = en;
      bus0.pkt_data = d;
    end else begin
      bus2.pkt_en   = en;
      bus2.pkt_data = d;
    end
  endtask

  // {uart_txd, tx_busy, tx_done} of the selected instance.
  function automatic logic [2:0] sample(input int sel);
    if (sel == 0) return {bus0.uart_txd, bus0.tx_busy, bus0.tx_done};
    else          return {bus2.uart_txd, bus2.tx_busy, bus2.tx_done};
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Sends one packet starting at the current negedge and checks it cycle by
  // cycle. intr_at: cycle of an extra pkt_en while busy (must be ignored).
  // rst_at: cycle at which reset is asserted to abort the packet.
  // Returns at a negedge with the DUT idle, so a following call is accepted
  // in the first idle cycle (back-to-back case).
  task automatic run_pkt(input int sel, input logic [127:0] data,
                         input int intr_at, input int rst_at);
    bit          exp_bits[$];
    bit          centre[$];
    int          gap, len, base;
    int          txd_err, busy_err, done_err, done_cyc;
    logic [2:0]  s;
    logic        exp_txd;
    logic [7:0]  byt, got;

    gap = (sel == 0) ? 0 : 2;
    for (int b = 0; b < 16; b++) begin
      byt = data[8*b +: 8];
      exp_bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) exp_bits.push_back(byt[i]);
`ifdef UART_TX_PARITY_EN
      exp_bits.push_back(^byt);
`endif
      exp_bits.push_back(1'b1);
      if (b < 15) for (int g = 0; g < gap; g++) exp_bits.push_back(1'b1);
    end
    len = exp_bits.size() * BPS;

    txd_err  = 0;
    busy_err = 0;
    done_err = 0;
    done_cyc = -1;

    drive(sel, 1'b1, data);
    for (int k = 1; k <= len + 1; k++) begin
      @(negedge clk);
      if (k == rst_at) begin
        rst_n = 1'b0;
        #1;
        s = sample(sel);
        check("rst_mid_txd",  s[2], 1'b1);
        check("rst_mid_busy", s[1], 1'b0);
        check("rst_mid_done", s[0], 1'b0);
        drive(sel, 1'b0, rnd128());
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        s = sample(sel);
        check("post_rst_idle", s, 3'b100);
        return;
      end
      s = sample(sel);
      exp_txd = (k <= len) ? exp_bits[(k-1)/BPS] : 1'b1;
      if (s[2] !== exp_txd) txd_err++;
      if (s[1] !== (k <= len)) busy_err++;
      if (s[0] !== (k == len)) done_err++;
      if (s[0] === 1'b1 && done_cyc < 0) done_cyc = k;
      if (k == 1) begin
        check("start_txd",  s[2], 1'b0);
        check("start_busy", s[1], 1'b1);
      end
      if (k <= len && ((k-1) % BPS) == BPS/2) centre.push_back(s[2]);
      // Extra requests mid-packet and on the tx_done cycle must be ignored.
      if (k == intr_at || k == len) drive(sel, 1'b1, rnd128());
      else                          drive(sel, 1'b0, rnd128());
    end

    check($sformatf("txd_wave_errs_g%0d", gap), txd_err, 0);
    check($sformatf("busy_errs_g%0d", gap), busy_err, 0);
    check($sformatf("done_errs_g%0d", gap), done_err, 0);
    check($sformatf("done_cycle_g%0d", gap), done_cyc,
          16 * (10 + PAR + gap) * BPS - gap * BPS);

    // Decode bytes from bit-centre samples, as a receiver would.
    for (int b = 0; b < 16; b++) begin
      base = b * (FRAME + gap);
      byt  = data[8*b +: 8];
      got  = '0;
      for (int i = 0; i < 8; i++) got[i] = centre[base + 1 + i];
      check($sformatf("byte%0d_g%0d", b, gap), got, byt);
`ifdef UART_TX_PARITY_EN
      check($sformatf("parity%0d_g%0d", b, gap), centre[base + 9], ^byt);
`endif
    end
  endtask

  initial begin
    logic [127:0] cnt;
    int           sel;

    rst_n = 1'b0;
    drive(0, 1'b0, '0);
    drive(1, 1'b0, '0);
    repeat (3) @(negedge clk);
    check("reset_state_g0", sample(0), 3'b100);
    check("reset_state_g2", sample(1), 3'b100);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_rst", sample(0), 3'b100);

    for (int b = 0; b < 16; b++) cnt[8*b +: 8] = 8'(b);

    run_pkt(0, cnt, -1, -1);                          // bytes 00..0F
    run_pkt(0, 128'hA5, -1, -1);                       // bit order / timing
    run_pkt(0, rnd128(), 500, -1);                     // busy ignore
    run_pkt(0, rnd128(), -1, 735);                     // reset mid-byte
    run_pkt(0, rnd128(), -1, -1);                      // full packet after reset
    run_pkt(1, cnt, -1, -1);                           // GAP_BITS=2
    run_pkt(1, rnd128(), int'($urandom_range(50, 1850)), -1);
    run_pkt(0, {112'h0, 8'h03, 8'h07}, -1, -1);        // parity 1 then 0
    for (int n = 0; n < 4; n++) begin
      sel = int'($urandom_range(0, 1));
      run_pkt(sel, rnd128(), int'($urandom_range(2, 1500)), -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_pkt_tx.md
Name: uart_pkt_tx

Overview:
- Packet-level UART transmitter. Takes a 128-bit word and sends it as 16 back-to-back 8N1 bytes on uart_txd.
- Pairs with the 128-bit packet receiver on the far end of the link.
- Sits between the loopback/application logic and the TX pin. Uses the same CLK_FREQ/UART_BPS scheme as the packet receiver.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- UART_BPS, 115200, baud rate. Bit period BPS_CNT = CLK_FREQ/UART_BPS clock cycles, integer-truncated (434 at defaults).
- GAP_BITS, 0, idle (mark) bit-times inserted between consecutive bytes of one packet. Range 0..15.

Ports:
- sys_clk  input  1  system clock.
- sys_rst_n  input  1  reset. Asynchronous assert, active-low.
- pkt_en  input  1  start request, sampled every cycle.
- pkt_data  input  128  packet payload, sampled on acceptance only.
- tx_busy  output  1  high while a packet is in flight.
- tx_done  output  1  one-cycle pulse at packet completion.
- uart_txd  output  1  serial line, idle high, registered.

Interface (already decided): one clock, sys_clk. sys_rst_n is asynchronous and active-low.

Behaviour:
- Reset values: uart_txd=1, tx_busy=0, tx_done=0. FSM=IDLE; bit counter, byte counter and baud counter all 0. Reset asserted mid-packet aborts immediately: txd returns to 1 asynchronously and the remaining bytes are discarded.
- Acceptance: in IDLE, when pkt_en=1, pkt_data is latched into a 128-bit shift register. pkt_en while tx_busy=1 is ignored; there is no queueing.
- Latency: on the cycle after acceptance, tx_busy=1 and uart_txd=0 (start bit).
- Byte order: byte 0 = pkt_data[7:0] is sent first, byte 15 = pkt_data[127:120] last. Bits within a byte go LSB first.
- Baud counter: counts 0..BPS_CNT-1. Each bit holds uart_txd for exactly BPS_CNT cycles. The counter clears on every state change.
- FSM states: IDLE -> START -> DATA(x8) -> [PARITY] -> STOP -> GAP -> START ...
  - IDLE -> START: on acceptance.
  - START -> DATA: after one bit period.
  - DATA: after 8 bit periods -> PARITY if enabled, else STOP.
  - STOP: drives 1 for one bit period. On completion:
    - if byte counter = 15 -> IDLE.
    - else if GAP_BITS>0 -> GAP.
    - else -> START of the next byte.
  - GAP: drives 1 for GAP_BITS bit periods, then -> START.
- Byte counter: 4 bits, increments at each STOP completion. Wrap from 15 coincides with the return to IDLE.
- Completion: on the last cycle of byte 15's stop bit, tx_done=1 for one cycle. On the next cycle tx_busy=0, FSM=IDLE, uart_txd=1.
- Back-to-back packets: pkt_en=1 in the first IDLE cycle after completion is accepted. The minimum idle between packets is 1 cycle.
- Simultaneous tx_done and pkt_en=1 in the same cycle: pkt_en is ignored, because the FSM is not yet in IDLE.
- Packet duration: 16 × (10 + P + GAP_BITS) × BPS_CNT cycles, minus GAP_BITS × BPS_CNT because there is no trailing gap. P = 1 with parity, else 0. At defaults: 69440 cycles.
- uart_txd is driven from a flop, never combinationally.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: a PARITY state follows DATA and sends one even-parity bit (XOR of the 8 data bits) for one bit period. Frame becomes 8E1, 11 bits per byte.
- Undefined: no PARITY state, 8N1 framing, 10 bits per byte.

Test Plan (bench: CLK_FREQ=1000000, UART_BPS=100000, so BPS_CNT=10):
- Basic: pkt_data=128'h0F0E..0100 (byte k=k), pulse pkt_en -> one cycle later txd=0 and busy=1. Sampling at bit centres yields bytes 00..0F in order. tx_done pulses at cycle 1600 after acceptance, then busy=0.
- Bit order: pkt_data[7:0]=8'hA5, rest 0 -> first frame bits 0,1,0,1,0,0,1,0,1,1. Each bit lasts exactly 10 cycles.
- Busy ignore: second pkt_en with different data at cycle 500 of a packet -> output stream unchanged. No second packet follows tx_done.
- Reset mid-op: assert sys_rst_n=0 at cycle 735 (during a data bit) -> txd=1, busy=0, done=0 immediately. After release, a new pkt_en sends a full, correct 16-byte packet.
- GAP_BITS=2: -> 20 idle-high cycles between each stop bit and the next start bit. Total packet length 1600+15×20=1900 cycles.
- With UART_TX_PARITY_EN: byte 8'h07 -> parity bit 1, byte 8'h03 -> 0. Packet length 1760 cycles.
